// File: rtl/trigger_judge_pkg.sv
// Shared definitions for the trigger judge: FSM encoding, lane geometry and
// the threshold arithmetic used to turn a percentage into a sample level.
package trigger_judge_pkg;

    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_REARM   = 2'd2
    } state_t;

    // Percentage of positive full scale, truncated toward zero.
    function automatic int calc_threshold(input int pct, input int res_w);
        return (pct * (1 << (res_w - 1))) / 100;
    endfunction

endpackage

// File: rtl/sample_comparator.sv
// Flags a beat as hot when any lane's MSB-aligned signed sample exceeds the
// threshold. Purely combinational; the caller registers whatever it derives.
module sample_comparator
    import trigger_judge_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int THRESHOLD_VAL        = 204
) (
    input  logic [S_AXIS_TDATA_WIDTH-1:0] tdata,
    output logic                          hot
);

    localparam int LANES = S_AXIS_TDATA_WIDTH / LANE_W;
    // One extra bit so a 100 % threshold (2^(N-1)) still fits as a positive value.
    localparam int CMP_W = ADC_RESOLUTION_WIDTH + 1;
    localparam logic signed [CMP_W-1:0] THR = CMP_W'(THRESHOLD_VAL);

    logic signed [CMP_W-1:0] sample;

    // Sub-resolution LSBs of each lane carry no sample information.
    wire unused_lsbs = ^tdata;

    // Sign-extend each lane's sample and OR together the strict-greater compares.
    always_comb begin
        hot    = 1'b0;
        sample = '0;
        for (int i = 0; i < LANES; i++) begin
            sample = {tdata[i*LANE_W + LANE_W - 1],
                      tdata[i*LANE_W + LANE_W - ADC_RESOLUTION_WIDTH +: ADC_RESOLUTION_WIDTH]};
            if (sample > THR) begin
                hot = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trigger_judge.sv
// Watches an ADC stream and opens a fixed-length acquisition window on the
// first beat whose sample crosses the threshold, with rearm hysteresis.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | armed, waiting for a hot beat (dropped if downstream is full)
// ST_ACQUIRE | window open, counting POST_ACQUI_LEN beats after the trigger
// ST_REARM   | window closed, waiting for one cold beat before rearming
module trigger_judge
    import trigger_judge_pkg::*;
#(
    parameter int THRESHOLD            = 10,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int TIME_STAMP_WIDTH     = 16,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    input  logic                          S_AXIS_TREADY,
    input  logic                          FIFO_FULL,
    output logic                          TRIGGERD_FLAG,
    output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
    output logic [CNT_WIDTH-1:0]          TRIG_CNT,
    output logic [CNT_WIDTH-1:0]          LOST_TRIG_CNT
);

    localparam int THRESHOLD_VAL = calc_threshold(THRESHOLD, ADC_RESOLUTION_WIDTH);
    localparam int WIN_W = (POST_ACQUI_LEN > 2) ? $clog2(POST_ACQUI_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POST_ACQUI_LEN - 1);

    state_t                        state, state_nxt;
    logic [TIME_STAMP_WIDTH-1:0]   beat_cnt, beat_cnt_nxt, ts_nxt;
    logic [WIN_W-1:0]              win_cnt, win_cnt_nxt;
    logic [CNT_WIDTH-1:0]          trig_nxt, lost_nxt;
    logic                          flag_nxt;
    logic                          hot;
    logic                          beat;

    assign beat = S_AXIS_TVALID & S_AXIS_TREADY;

    sample_comparator #(
        .S_AXIS_TDATA_WIDTH   (S_AXIS_TDATA_WIDTH),
        .ADC_RESOLUTION_WIDTH (ADC_RESOLUTION_WIDTH),
        .THRESHOLD_VAL        (THRESHOLD_VAL)
    ) u_sample_comparator (
        .tdata (S_AXIS_TDATA),
        .hot   (hot)
    );

    // Next-state and next-output decisions; nothing moves on a cycle without a beat.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        win_cnt_nxt  = win_cnt;
        ts_nxt       = TIME_STAMP;
        trig_nxt     = TRIG_CNT;
        lost_nxt     = LOST_TRIG_CNT;

        if (beat) begin
            beat_cnt_nxt = beat_cnt + TIME_STAMP_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (hot) begin
                        if (FIFO_FULL) begin
                            if (LOST_TRIG_CNT != '1) lost_nxt = LOST_TRIG_CNT + CNT_WIDTH'(1);
                        end else begin
                            state_nxt   = ST_ACQUIRE;
                            ts_nxt      = beat_cnt;
                            win_cnt_nxt = '0;
                            if (TRIG_CNT != '1) trig_nxt = TRIG_CNT + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_ACQUIRE: begin
                    // The window closes on the POST_ACQUI_LEN-th beat after the trigger.
                    if (win_cnt == WIN_LAST) begin
                        state_nxt   = ST_REARM;
                        win_cnt_nxt = '0;
                    end else begin
                        win_cnt_nxt = win_cnt + WIN_W'(1);
                    end
                end
                ST_REARM: begin
                    if (!hot) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        flag_nxt = (state_nxt == ST_ACQUIRE);
    end

    // State, counters and all outputs registered; reset wins over any beat.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            win_cnt       <= '0;
            TRIGGERD_FLAG <= 1'b0;
            TIME_STAMP    <= '0;
            TRIG_CNT      <= '0;
            LOST_TRIG_CNT <= '0;
        end else begin
            state         <= state_nxt;
            beat_cnt      <= beat_cnt_nxt;
            win_cnt       <= win_cnt_nxt;
            TRIGGERD_FLAG <= flag_nxt;
            TIME_STAMP    <= ts_nxt;
            TRIG_CNT      <= trig_nxt;
            LOST_TRIG_CNT <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_trigger_judge.sv
// Bench for trigger_judge: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model.
module tb_trigger_judge;

    localparam int PAL   = 38;
    localparam int THR_V = (10 * 2048) / 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] tdata = '0;
    logic         tvalid = 1'b0;
    logic         tready = 1'b0;
    logic         ff = 1'b0;
    logic         flag;
    logic [15:0]  ts;
    logic [15:0]  trig_cnt;
    logic [15:0]  lost_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: beats remaining in the window and whether a cold beat is owed.
    int m_beat = 0;
    int m_left = 0;
    bit m_need_cold = 1'b0;
    int m_ts = 0;
    int m_trig = 0;
    int m_lost = 0;

    trigger_judge dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .FIFO_FULL     (ff),
        .TRIGGERD_FLAG (flag),
        .TIME_STAMP    (ts),
        .TRIG_CNT      (trig_cnt),
        .LOST_TRIG_CNT (lost_cnt)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic bit is_hot(input logic [127:0] d);
        logic signed [11:0] s;
        for (int i = 0; i < 8; i++) begin
            s = d[i*16+4 +: 12];
            if (int'(s) > THR_V) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [127:0] mk(input int lane, input int val);
        logic [127:0] w;
        logic [11:0]  v12;
        w   = '0;
        v12 = 12'(val);
        w[lane*16 +: 16] = {v12, 4'h0};
        return w;
    endfunction

    function automatic logic [127:0] cold_rand();
        logic [127:0] w;
        logic [11:0]  v12;
        int           s;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            s   = int'($urandom_range(2252, 0)) - 2048;
            v12 = 12'(s);
            w[i*16 +: 16] = {v12, 4'($urandom_range(15, 0))};
        end
        return w;
    endfunction

    function automatic logic [127:0] hot_rand();
        logic [127:0] w;
        logic [11:0]  v12;
        int           lane;
        w    = cold_rand();
        lane = int'($urandom_range(7, 0));
        v12  = 12'($urandom_range(2047, 205));
        w[lane*16 +: 16] = {v12, 4'($urandom_range(15, 0))};
        return w;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; inputs are consumed at the next rising edge
    // and the task returns at the following falling edge.
    task automatic step(input logic [127:0] d, input bit v, input bit r,
                        input bit f, input bit a);
        tdata  = d;
        tvalid = v;
        tready = r;
        ff     = f;
        rst    = a;
        @(negedge clk);
    endtask

    // Behavioural reference: applies the trigger rules to each handshake beat.
    always @(posedge clk) begin : model
        int b, left, t, tr, lo;
        bit nc, h;
        b = m_beat; left = m_left; t = m_ts; tr = m_trig; lo = m_lost; nc = m_need_cold;
        if (rst) begin
            b = 0; left = 0; t = 0; tr = 0; lo = 0; nc = 1'b0;
        end else if (tvalid && tready) begin
            h = is_hot(tdata);
            if (left > 0) begin
                left--;
                if (left == 0) nc = 1'b1;
            end else if (nc) begin
                if (!h) nc = 1'b0;
            end else if (h) begin
                if (ff) begin
                    if (lo < 65535) lo++;
                end else begin
                    if (tr < 65535) tr++;
                    t    = b;
                    left = PAL;
                end
            end
            b = (b + 1) % 65536;
        end
        m_beat <= b; m_left <= left; m_ts <= t; m_trig <= tr; m_lost <= lo; m_need_cold <= nc;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("flag", int'(flag), (m_left > 0) ? 1 : 0);
            check("time_stamp", int'(ts), m_ts);
            check("trig_cnt", int'(trig_cnt), m_trig);
            check("lost_trig_cnt", int'(lost_cnt), m_lost);
        end
    end

    initial begin
        int cnt;
        int guard;
        int nb;
        bit v;

        @(negedge clk);
        step('0, 1, 1, 0, 1);
        chk_en = 1'b1;
        check("reset_flag", int'(flag), 0);
        check("reset_trig", int'(trig_cnt), 0);

        // Trigger at beat 10, window length under continuous beats.
        for (int i = 0; i < 10; i++) step('0, 1, 1, 0, 0);
        step(mk(3, 205), 1, 1, 0, 0);
        check("a_flag", int'(flag), 1);
        check("a_ts", int'(ts), 10);
        check("a_trig", int'(trig_cnt), 1);
        cnt = 1;
        guard = 0;
        while (flag === 1'b1 && guard < 100) begin
            step('0, 1, 1, 0, 0);
            guard++;
            if (flag === 1'b1) cnt++;
        end
        check("a_flag_cycles", cnt, 38);

        // Threshold boundary: 204 and -2048 stay cold, 205 triggers.
        step('0, 1, 1, 0, 1);
        step(mk(0, 204) | mk(1, -2048), 1, 1, 0, 0);
        check("b_edge_flag", int'(flag), 0);
        check("b_edge_trig", int'(trig_cnt), 0);
        step(mk(5, 205), 1, 1, 0, 0);
        check("b_hot_flag", int'(flag), 1);
        check("b_hot_ts", int'(ts), 1);

        // Lost trigger on full FIFO, then accepted trigger; no-beat cycle ignored.
        step('0, 1, 1, 0, 1);
        step(mk(2, 300), 1, 0, 0, 0);
        check("c_nobeat_flag", int'(flag), 0);
        step(mk(2, 300), 1, 1, 1, 0);
        check("c_lost", int'(lost_cnt), 1);
        check("c_lost_flag", int'(flag), 0);
        step(mk(2, 300), 1, 1, 0, 0);
        check("c_trig_flag", int'(flag), 1);
        check("c_trig_ts", int'(ts), 1);

        // Hot held through the window with FIFO full, rearm hysteresis.
        step('0, 1, 1, 0, 1);
        step(mk(4, 1000), 1, 1, 0, 0);
        for (int i = 0; i < 37; i++) step(mk(4, 1000), 1, 1, 1, 0);
        check("d_flag_hold", int'(flag), 1);
        step(mk(4, 1000), 1, 1, 1, 0);
        check("d_flag_end", int'(flag), 0);
        for (int i = 0; i < 3; i++) step(mk(4, 1000), 1, 1, 1, 0);
        check("d_no_retrig", int'(flag), 0);
        check("d_lost_zero", int'(lost_cnt), 0);
        step('0, 1, 1, 0, 0);
        step(mk(6, 700), 1, 1, 0, 0);
        check("d_retrig_flag", int'(flag), 1);
        check("d_retrig_cnt", int'(trig_cnt), 2);
        check("d_retrig_ts", int'(ts), 43);

        // Reset in the middle of a window.
        step('0, 1, 1, 0, 1);
        step(mk(0, 500), 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step('0, 1, 1, 0, 0);
        check("e_flag_mid", int'(flag), 1);
        step(mk(0, 500), 1, 1, 0, 1);
        check("e_rst_flag", int'(flag), 0);
        check("e_rst_trig", int'(trig_cnt), 0);
        check("e_rst_ts", int'(ts), 0);
        step(mk(0, 500), 1, 1, 0, 0);
        check("e_after_ts", int'(ts), 0);
        check("e_after_trig", int'(trig_cnt), 1);

        // Beat counter wrap and a 50 % TVALID window.
        step('0, 1, 1, 0, 1);
        for (int i = 0; i < 65535; i++) step('0, 1, 1, 0, 0);
        step(mk(1, 900), 1, 1, 0, 0);
        check("f_ts_top", int'(ts), 65535);
        nb = 0;
        guard = 0;
        while (flag === 1'b1 && guard < 400) begin
            v = guard[0];
            step(mk(1, 900), v, 1, 0, 0);
            if (v) nb++;
            guard++;
        end
        check("f_window_beats", nb, 38);
        step('0, 1, 1, 0, 0);
        step(mk(1, 900), 1, 1, 0, 0);
        check("f_ts_wrapped", int'(ts), 39);

        // Randomized traffic.
        step('0, 1, 1, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(5, 0) == 0) ? hot_rand() : cold_rand(),
                 $urandom_range(3, 0) != 0,
                 $urandom_range(3, 0) != 0,
                 $urandom_range(3, 0) == 0,
                 $urandom_range(199, 0) == 0);
        end

        step('0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trigger_judge.md
TRIGGER_JUDGE -- requirements
Module: trigger_judge

Interface
REQ-001 SHALL have parameter THRESHOLD, default 10, trigger level in percent of positive full scale 2^(ADC_RESOLUTION_WIDTH-1).
REQ-002 SHALL have parameter POST_ACQUI_LEN, default 38, TRIGGERD_FLAG high length in handshake beats.
REQ-003 SHALL have parameters TIME_STAMP_WIDTH (default 16), ADC_RESOLUTION_WIDTH (default 12), S_AXIS_TDATA_WIDTH (default 128), CNT_WIDTH (default 16), lane width fixed at 16 bits.
REQ-004 SHALL have port AXIS_ACLK  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port AXIS_ARESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port S_AXIS_TDATA  input  S_AXIS_TDATA_WIDTH  monitored ADC stream, 8 lanes of 16 bits.
REQ-007 SHALL have ports S_AXIS_TVALID and S_AXIS_TREADY, each input 1, monitored handshake; beat = TVALID&TREADY.
REQ-008 SHALL have port FIFO_FULL  input  1  downstream buffer full.
REQ-009 SHALL have port TRIGGERD_FLAG  output  1  acquisition window active.
REQ-010 SHALL have port TIME_STAMP  output  TIME_STAMP_WIDTH  beat index of triggering beat.
REQ-011 SHALL have ports TRIG_CNT and LOST_TRIG_CNT, each output CNT_WIDTH, accepted and suppressed trigger counts.

Function
REQ-012 Sample per lane SHALL be lane[15:16-ADC_RESOLUTION_WIDTH], signed two's complement, MSB-aligned.
REQ-013 THRESHOLD_VAL SHALL be (THRESHOLD * 2^(ADC_RESOLUTION_WIDTH-1)) / 100, integer truncation (default 204).
REQ-014 Beat is "hot" when any lane sample > THRESHOLD_VAL (strictly greater, signed compare); "cold" when all lanes <= THRESHOLD_VAL.
REQ-015 Free-running beat counter SHALL increment by 1 per beat, wrap modulo 2^TIME_STAMP_WIDTH, first beat after reset = 0.
REQ-016 States SHALL be IDLE, ACQUIRE, REARM.
REQ-017 IDLE: hot beat with FIFO_FULL=0 -> ACQUIRE, TRIGGERD_FLAG=1 and TIME_STAMP=beat counter of that beat from next edge, TRIG_CNT+1.
REQ-018 IDLE: hot beat with FIFO_FULL=1 -> stay IDLE, LOST_TRIG_CNT+1, TRIGGERD_FLAG stays 0, TIME_STAMP unchanged.
REQ-019 ACQUIRE: window counter SHALL count beats, triggering beat excluded; hot beats ignored (no extension, no counting).
REQ-020 ACQUIRE: on the beat that brings window count to POST_ACQUI_LEN-1 -> REARM, TRIGGERD_FLAG=0 from next edge; continuous TVALID gives flag high exactly POST_ACQUI_LEN cycles.
REQ-021 Cycles without beat SHALL freeze window counter, beat counter and state.
REQ-022 REARM: cold beat -> IDLE; hot beat -> stay REARM (hysteresis, no trigger, no counter change).
REQ-023 TIME_STAMP SHALL hold until next accepted trigger.
REQ-024 TRIG_CNT and LOST_TRIG_CNT SHALL saturate at 2^CNT_WIDTH-1.
REQ-025 FIFO_FULL SHALL be sampled only in IDLE at a hot beat; FIFO_FULL during ACQUIRE SHALL not abort the window.
REQ-026 All outputs SHALL be registered; trigger latency one clock from triggering beat edge.

Reset
REQ-027 AXIS_ARESET=1 at an edge SHALL force state IDLE, TRIGGERD_FLAG=0, TIME_STAMP=0, TRIG_CNT=0, LOST_TRIG_CNT=0, beat and window counters 0.
REQ-028 Reset mid-ACQUIRE SHALL drop TRIGGERD_FLAG at the same edge; reset dominates concurrent beats.

Structure
REQ-029 Shared package/header SHALL hold state encoding, lane width 16 and THRESHOLD_VAL computation.
REQ-030 One sub-module sample_comparator SHALL take S_AXIS_TDATA and return registered-free hot flag; instantiated once.

Verification
REQ-031 Continuous beats, lane3=205 (<<4) at beat 10 -> TRIGGERD_FLAG high cycles 11..48, TIME_STAMP=10, TRIG_CNT=1.
REQ-032 Lane sample exactly 204 and -2048 -> no trigger; 205 -> trigger.
REQ-033 Hot beat with FIFO_FULL=1 -> LOST_TRIG_CNT=1, flag 0; following hot beat with FIFO_FULL=0 -> trigger.
REQ-034 Hot held through window end -> REARM, no retrigger until one cold beat, next hot beat triggers, TRIG_CNT=2.
REQ-035 TVALID toggling 50% during ACQUIRE -> flag high spans 38 beats after triggering beat; beat counter wraps 65535->0 correctly.
REQ-036 AXIS_ARESET pulse at window beat 20 -> flag 0, all counters 0, next hot beat stamped from 0.
